dequantize: RTL and testbench
=============================

// Module: dequantize
// PURPOSE
// - Inverse of the VSQ quantizer. Reads 64 rows of INT4 x 16 lanes from the output RAM and applies the
//   captured per-lane scale factor (Q30.10). Emits reconstructed Q30.10 x 16 rows on a valid/ready stream.
// - Sits between the quantized-activation RAM and the next matmul stage. Also serves as the bit-exact
//   reference path for checking quantizer error.
// PARAMETERS
// - N_LANE  16  lanes per row
// - DW      40  scale-factor / output width per lane (Q30.10)
// - QW      4   quantized element width (signed INT4)
// - DEPTH   64  rows per block
// - AW      6   RAM address width, DEPTH = 2**AW
// PORTS
// - i_clk       in   1          clock
// - i_rst_n     in   1          asynchronous, active-low reset
// - i_sf_valid  in   1          scale-factor bus valid (quantizer o_sf_valid)
// - i_sf_data   in   N_LANE*DW  per-lane scale factors, Q30.10, lane g at [g*DW +: DW]
// - i_start     in   1          one-cycle pulse: dequantize one block of DEPTH rows
// - o_ram_re    out  1          RAM read enable
// - o_ram_addr  out  AW         RAM read address
// - i_ram_data  in   N_LANE*QW  RAM read data, valid exactly 1 cycle after o_ram_re
// - o_valid     out  1          output row valid
// - i_ready     in   1          downstream ready; a row transfers when o_valid & i_ready
// - o_data      out  N_LANE*DW  dequantized row, Q30.10, lane g at [g*DW +: DW]
// - o_busy      out  1          high from accepted i_start until o_done
// - o_done      out  1          one-cycle pulse in the cycle the last row (row DEPTH-1) transfers
// BEHAVIOUR
// - Reset: all outputs 0; state S_IDLE; sf_r, row counters, buffer cleared.
// - sf capture: sf_r <= i_sf_data each cycle that i_sf_valid=1 and state==S_IDLE. Ignored while busy.
// - FSM:
//   - S_IDLE -> S_RUN on i_start. Clears rd_addr and out_cnt; o_busy=1 from the next cycle.
//   - S_RUN issues reads. Go to S_DRAIN after issuing addr DEPTH-1.
//   - S_DRAIN -> S_IDLE in the cycle row DEPTH-1 transfers. o_done=1 that cycle.
//   - i_start outside S_IDLE is ignored.
// - Read issue: o_ram_re=1 in S_RUN when (buffered rows + reads in flight) < 2.
//   - o_ram_addr = rd_addr; rd_addr increments on each issue. o_ram_re=0 otherwise.
//   - o_ram_addr holds its last value when idle.
// - Datapath: each returned word is dequantized in its return cycle and pushed into a 2-entry output FIFO.
//   - out[g] = low DW bits of ($signed(q[g]) * $signed(sf_r[g])), q sign-extended from QW bits.
//   - Products are two's complement and take the low DW bits with no saturation. sf < 2^36 cannot overflow.
// - Output: o_valid = FIFO non-empty; o_data = FIFO head, registered, with no combinational path from i_ram_data.
//   - Minimum latency: i_start -> first o_valid is 3 cycles (start, read, return/push).
//   - Rows appear in address order 0..DEPTH-1, exactly once each.
// - Backpressure: i_ready=0 holds o_valid/o_data stable. Credit rule guarantees the FIFO never overflows.
//   - Push and pop in the same cycle are both honoured.
// - Full throughput: with i_ready=1 constantly, one row per cycle. Last row at start+DEPTH+2 cycles.
// - Reset mid-block: asynchronous return to S_IDLE; FIFO emptied, sf_r cleared, no o_done.
// STRUCTURE
// - Shared package/header: N_LANE, DW, QW, DEPTH, AW. Also FSM state encodings S_IDLE/S_RUN/S_DRAIN,
//   shared with the quantizer.
// - One sub-module: dq_lane (combinational per-lane sign-extend + multiply + truncate), generated N_LANE times.
// - FIFO, credit counter and FSM stay in the top level.
// TESTING
// - Reset: with i_rst_n=0, every output is 0. Release, then start with sf_r=0 -> 64 rows of all-zero o_data, then o_done.
// - Scale: sf lane0=0x400 (1.0), lane15=0x1C00 (7.0); RAM row0 lane0=4'h7, lane15=4'h8
//   -> row0 lane0=0x1C00, lane15 = -56.0 = 40'hFF_FFFF_2000.
// - Stream: i_ready=1 always, RAM[k] all lanes = k[3:0]. Expect 64 rows in order, one per cycle, and
//   o_done coincident with row 63. o_busy falls the next cycle.
// - Backpressure: i_ready toggles randomly 50%. Expect no row lost or duplicated, o_data stable while stalled,
//   o_ram_re never raised with 2 credits used.
// - Ignored events: i_start and i_sf_valid with new sf during the block -> no effect.
//   The new sf is captured only after return to S_IDLE.
// - Reset mid-block: assert i_rst_n=0 at row 30. Outputs drop to 0 immediately, no o_done.
//   A fresh start then yields rows 0..63.

Source files
------------

// File: rtl/dequantize_pkg.sv
// rtl/dequantize_pkg.sv - shared dequantizer parameters and FSM state encodings
package dequantize_pkg;

  localparam int N_LANE = 16;
  localparam int DW     = 40;
  localparam int QW     = 4;
  localparam int DEPTH  = 64;
  localparam int AW     = 6;

  // Same encodings as the quantizer so both blocks read alike in waveforms.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } dq_state_e;

endpackage

// File: rtl/dq_lane.sv
// rtl/dq_lane.sv - one lane: sign-extend INT4, multiply by Q30.10 scale, keep low DW bits
module dq_lane
  import dequantize_pkg::*;
(
  input  logic [QW-1:0] i_q,
  input  logic [DW-1:0] i_sf,
  output logic [DW-1:0] o_out
);

  logic signed [DW-1:0] q_ext;

  assign q_ext = {{(DW-QW){i_q[QW-1]}}, i_q};
  // A DW-wide context keeps only the low DW bits of the product; wrap, no saturation.
  assign o_out = q_ext * $signed(i_sf);

endmodule

// File: rtl/dequantize.sv
// rtl/dequantize.sv - streams one block of INT4 rows from RAM out as scaled Q30.10 rows
module dequantize
  import dequantize_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_sf_valid,
  input  logic [N_LANE*DW-1:0] i_sf_data,
  input  logic                 i_start,
  output logic                 o_ram_re,
  output logic [AW-1:0]        o_ram_addr,
  input  logic [N_LANE*QW-1:0] i_ram_data,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [N_LANE*DW-1:0] o_data,
  output logic                 o_busy,
  output logic                 o_done
);

  dq_state_e            state_q, state_d;
  logic [N_LANE*DW-1:0] sf_q, sf_d;
  logic [AW-1:0]        rd_addr_q, rd_addr_d;
  logic [AW-1:0]        out_cnt_q, out_cnt_d;
  logic                 inflight_q, inflight_d;
  logic [1:0]           fifo_cnt_q, fifo_cnt_d;
  logic                 wr_ptr_q, wr_ptr_d;
  logic                 rd_ptr_q, rd_ptr_d;
  logic [N_LANE*DW-1:0] mem_q [2];
  logic [N_LANE*DW-1:0] mem_d [2];

  logic [N_LANE*DW-1:0] lane_row;
  logic                 push, pop, issue, done;
  logic [2:0]           credits;

  for (genvar g = 0; g < N_LANE; g++) begin : g_lane
    dq_lane u_lane (
      .i_q   (i_ram_data[g*QW +: QW]),
      .i_sf  (sf_q[g*DW +: DW]),
      .o_out (lane_row[g*DW +: DW])
    );
  end

  // Next-state: FSM, read issue with 2-row credit, output FIFO bookkeeping.
  always_comb begin
    state_d    = state_q;
    sf_d       = sf_q;
    rd_addr_d  = rd_addr_q;
    out_cnt_d  = out_cnt_q;
    fifo_cnt_d = fifo_cnt_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    mem_d      = mem_q;

    pop  = (fifo_cnt_q != 2'd0) && i_ready;
    push = inflight_q;
    // A row leaving this cycle frees its slot now, which keeps one row per cycle flowing.
    credits = 3'(fifo_cnt_q) + 3'(inflight_q) - 3'(pop);
    issue   = (state_q == S_RUN) && (credits < 3'd2);
    done    = (state_q == S_DRAIN) && pop && (out_cnt_q == AW'(DEPTH-1));
    inflight_d = issue;

    case (state_q)
      S_IDLE: begin
        if (i_sf_valid) sf_d = i_sf_data;
        if (i_start) begin
          state_d   = S_RUN;
          rd_addr_d = '0;
          out_cnt_d = '0;
        end
      end
      S_RUN: begin
        // The final address is held so o_ram_addr keeps it once idle.
        if (issue) begin
          if (rd_addr_q == AW'(DEPTH-1)) state_d = S_DRAIN;
          else                           rd_addr_d = rd_addr_q + AW'(1);
        end
      end
      S_DRAIN: begin
        if (done) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (pop) begin
      out_cnt_d = out_cnt_q + AW'(1);
      rd_ptr_d  = ~rd_ptr_q;
    end
    if (push) begin
      mem_d[wr_ptr_q] = lane_row;
      wr_ptr_d        = ~wr_ptr_q;
    end
    fifo_cnt_d = fifo_cnt_q + 2'(push) - 2'(pop);
  end

  // State registers with asynchronous clear.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      sf_q       <= '0;
      rd_addr_q  <= '0;
      out_cnt_q  <= '0;
      inflight_q <= 1'b0;
      fifo_cnt_q <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      mem_q[0]   <= '0;
      mem_q[1]   <= '0;
    end else begin
      state_q    <= state_d;
      sf_q       <= sf_d;
      rd_addr_q  <= rd_addr_d;
      out_cnt_q  <= out_cnt_d;
      inflight_q <= inflight_d;
      fifo_cnt_q <= fifo_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      mem_q      <= mem_d;
    end
  end

  assign o_ram_re   = issue;
  assign o_ram_addr = rd_addr_q;
  assign o_valid    = (fifo_cnt_q != 2'd0);
  assign o_data     = mem_q[rd_ptr_q];
  assign o_busy     = (state_q != S_IDLE);
  assign o_done     = done;

endmodule

// File: tb/tb_dequantize.sv
// tb/tb_dequantize.sv - randomized self-checking bench for dequantize
module tb_dequantize;
  import dequantize_pkg::*;

  localparam int RW  = N_LANE*DW;
  localparam int QRW = N_LANE*QW;

  logic           i_clk = 1'b0;
  logic           i_rst_n = 1'b0;
  logic           i_sf_valid = 1'b0;
  logic [RW-1:0]  i_sf_data = '0;
  logic           i_start = 1'b0;
  logic           o_ram_re;
  logic [AW-1:0]  o_ram_addr;
  logic [QRW-1:0] i_ram_data = '0;
  logic           o_valid;
  logic           i_ready = 1'b1;
  logic [RW-1:0]  o_data;
  logic           o_busy;
  logic           o_done;

  dequantize dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_sf_valid (i_sf_valid),
    .i_sf_data  (i_sf_data),
    .i_start    (i_start),
    .o_ram_re   (o_ram_re),
    .o_ram_addr (o_ram_addr),
    .i_ram_data (i_ram_data),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_data     (o_data),
    .o_busy     (o_busy),
    .o_done     (o_done)
  );

  always #5 i_clk = ~i_clk;

  logic [QRW-1:0] ram [DEPTH];
  always @(posedge i_clk) if (o_ram_re) i_ram_data <= ram[o_ram_addr];

  int cyc = 0;
  always @(posedge i_clk) cyc++;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [RW-1:0] got, input logic [RW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  logic [RW-1:0] model_sf = '0;
  logic [RW-1:0] exp_rows [DEPTH];
  logic [RW-1:0] prev_data, row0_got;
  bit mon_en = 0, prev_stall = 0, prev_done = 0, done_seen = 0, rand_ready = 0;
  int mon_idx, issued, taken, first_valid_cyc, done_cyc, start_cyc;

  initial forever begin
    @(posedge i_clk); #1;
    i_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Scoreboard: order, stability under stall, credit limit, done timing.
  always @(negedge i_clk) begin
    if (mon_en) begin
      if (prev_stall) begin
        chk("hold_valid", RW'(o_valid), RW'(1));
        chk("hold_data", o_data, prev_data);
      end
      if (prev_done) chk("busy_fall", RW'(o_busy), RW'(0));
      if (o_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (o_valid && i_ready) begin
        taken++;
        if (mon_idx < DEPTH) begin
          chk("row", o_data, exp_rows[mon_idx]);
          chk("done_flag", RW'(o_done), RW'(mon_idx == DEPTH-1));
          if (mon_idx == 0) row0_got = o_data;
        end else begin
          chk("extra_row", RW'(mon_idx), RW'(DEPTH-1));
        end
        mon_idx++;
      end else if (o_done) begin
        chk("stray_done", RW'(o_done), RW'(0));
      end
      if (o_ram_re) begin
        chk("credit", RW'((issued - taken) < 2), RW'(1));
        issued++;
      end
      if (o_done) begin
        done_seen = 1;
        done_cyc  = cyc;
      end
      prev_stall = o_valid && !i_ready;
      prev_data  = o_data;
      prev_done  = o_done;
    end
  end

  function automatic logic [RW-1:0] rand_wide();
    logic [RW-1:0] v;
    for (int i = 0; i < RW/32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic fill_ram_random();
    for (int k = 0; k < DEPTH; k++) ram[k] = {$urandom, $urandom};
  endtask

  task automatic load_sf(input logic [RW-1:0] sf);
    @(posedge i_clk); #1;
    i_sf_valid = 1'b1;
    i_sf_data  = sf;
    @(posedge i_clk); #1;
    i_sf_valid = 1'b0;
    model_sf   = sf;
  endtask

  // mode 0: plain block, 1: start/sf pulses mid-block, 2: reset at row 30
  task automatic run_block(input int mode);
    logic signed [QW-1:0] qs;
    logic signed [DW-1:0] ss;
    longint p;
    for (int k = 0; k < DEPTH; k++)
      for (int g = 0; g < N_LANE; g++) begin
        qs = ram[k][g*QW +: QW];
        ss = model_sf[g*DW +: DW];
        p  = longint'(qs) * longint'(ss);
        exp_rows[k][g*DW +: DW] = p[DW-1:0];
      end
    mon_idx = 0; issued = 0; taken = 0;
    prev_stall = 0; prev_done = 0; done_seen = 0;
    first_valid_cyc = -1; done_cyc = -1;
    mon_en = 1;
    @(posedge i_clk); #1;
    i_start   = 1'b1;
    start_cyc = cyc;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (done_seen) break;
      if (mode == 1) begin
        if (i == 8) begin
          i_start    = 1'b1;
          i_sf_valid = 1'b1;
          i_sf_data  = rand_wide();
        end
        if (i == 9)  i_start = 1'b0;
        if (i == 11) i_sf_valid = 1'b0;
      end
      if (mode == 2 && mon_idx >= 30) begin
        mon_en  = 0;
        i_rst_n = 1'b0;
        #1;
        chk("midrst_ctl", RW'({o_ram_re, o_ram_addr, o_valid, o_busy, o_done}), '0);
        chk("midrst_data", o_data, '0);
        model_sf = '0;
        repeat (2) @(posedge i_clk);
        #1;
        chk("midrst_hold", RW'({o_valid, o_busy, o_done}), '0);
        i_rst_n = 1'b1;
        return;
      end
      @(posedge i_clk); #1;
    end
    chk("done_seen", RW'(done_seen), RW'(1));
    chk("row_count", RW'(mon_idx), RW'(DEPTH));
    @(posedge i_clk); #1;
  endtask

  initial begin
    logic [RW-1:0] sf;
    for (int k = 0; k < DEPTH; k++) ram[k] = '0;
    repeat (3) @(posedge i_clk);
    #1;
    chk("rst_ctl", RW'({o_ram_re, o_ram_addr, o_valid, o_busy, o_done}), '0);
    chk("rst_data", o_data, '0);
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;

    // sf never loaded: all-zero rows
    fill_ram_random();
    run_block(0);

    // scale example
    sf = rand_wide();
    sf[0 +: DW]     = 40'h400;
    sf[15*DW +: DW] = 40'h1C00;
    fill_ram_random();
    ram[0][0 +: QW]     = 4'h7;
    ram[0][15*QW +: QW] = 4'h8;
    load_sf(sf);
    run_block(0);
    chk("scale_l0", RW'(row0_got[0 +: DW]), RW'(40'h1C00));
    chk("scale_l15", RW'(row0_got[15*DW +: DW]), RW'(40'hFF_FFFF_2000));

    // full-rate stream, RAM[k] = k[3:0] in every lane
    for (int k = 0; k < DEPTH; k++)
      for (int g = 0; g < N_LANE; g++) ram[k][g*QW +: QW] = 4'(k);
    load_sf(rand_wide());
    run_block(0);
    chk("first_latency", RW'(first_valid_cyc - start_cyc), RW'(3));
    chk("last_latency", RW'(done_cyc - start_cyc), RW'(DEPTH + 2));

    // random backpressure
    rand_ready = 1;
    for (int r = 0; r < 2; r++) begin
      fill_ram_random();
      load_sf(rand_wide());
      run_block(0);
    end

    // start and sf during a block are ignored; old sf persists afterwards
    fill_ram_random();
    run_block(1);
    fill_ram_random();
    run_block(0);
    load_sf(rand_wide());
    run_block(0);

    // reset at row 30, then a fresh block
    rand_ready = 0;
    fill_ram_random();
    run_block(2);
    load_sf(rand_wide());
    run_block(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
